// File: rtl/oscu_pkg.sv
// Shared types and default widths for the OSCU address sequencer.
package oscu_pkg;

  localparam int unsigned OSCU_NUM_CNT_BITS = 7;
  localparam int unsigned OSCU_STEP_BITS    = 3;
  localparam int unsigned OSCU_WRAP_BITS    = 4;

  // Encoding matches the raw 2-bit mode input: bit1 = down, bit0 = one-shot.
  typedef enum logic [1:0] {
    WRAP_UP      = 2'b00,
    ONESHOT_UP   = 2'b01,
    WRAP_DOWN    = 2'b10,
    ONESHOT_DOWN = 2'b11
  } cnt_mode_t;

  function automatic logic mode_is_up(input cnt_mode_t m);
    return (m == WRAP_UP) || (m == ONESHOT_UP);
  endfunction

  function automatic logic mode_is_oneshot(input cnt_mode_t m);
    return (m == ONESHOT_UP) || (m == ONESHOT_DOWN);
  endfunction

endpackage

// File: rtl/oscu_step_sat.sv
// Combinational next-address computation: step toward rollover_value,
// clamping on the terminal value instead of wrapping modulo 2^N.
module oscu_step_sat
  import oscu_pkg::*;
#(
  parameter int unsigned NUM_CNT_BITS = OSCU_NUM_CNT_BITS,
  parameter int unsigned STEP_BITS    = OSCU_STEP_BITS
) (
  input  logic [NUM_CNT_BITS-1:0] count,
  input  logic [NUM_CNT_BITS-1:0] rollover_value,
  input  logic [STEP_BITS-1:0]    step,
  input  logic                    up,
  output logic [NUM_CNT_BITS-1:0] next_count
);

  logic [NUM_CNT_BITS:0] count_ext;
  logic [NUM_CNT_BITS:0] roll_ext;
  logic [NUM_CNT_BITS:0] step_ext;
  logic [NUM_CNT_BITS:0] sum;
  logic [NUM_CNT_BITS:0] diff;

  assign count_ext = {1'b0, count};
  assign roll_ext  = {1'b0, rollover_value};
  assign step_ext  = (NUM_CNT_BITS+1)'(step);
  assign sum       = count_ext + step_ext;
  assign diff      = count_ext - step_ext;

  // Extra bit catches overflow (up) and borrow (down); either clamps to rollover.
  always_comb begin
    next_count = count;
    if (step != '0) begin
      if (up) begin
        if (sum > roll_ext) next_count = rollover_value;
        else                next_count = sum[NUM_CNT_BITS-1:0];
      end else begin
        if (diff[NUM_CNT_BITS] || (diff < roll_ext)) next_count = rollover_value;
        else                                         next_count = diff[NUM_CNT_BITS-1:0];
      end
    end
  end

endmodule

// File: rtl/oscu_addr_sequencer.sv
// Address sequencer: steps count_out toward rollover_value, then wraps to
// start_value (wrap modes) or stops with a sticky done (one-shot modes).
module oscu_addr_sequencer
  import oscu_pkg::*;
#(
  parameter int unsigned             NUM_CNT_BITS = OSCU_NUM_CNT_BITS,
  parameter int unsigned             STEP_BITS    = OSCU_STEP_BITS,
  parameter int unsigned             WRAP_BITS    = OSCU_WRAP_BITS,
  parameter logic [NUM_CNT_BITS-1:0] RESET_VAL    = '0
) (
  input  logic                    clk2,
  input  logic                    NReset,
  input  logic                    clear,
  input  logic                    count_enable,
  input  logic [1:0]              mode,
  input  logic [NUM_CNT_BITS-1:0] start_value,
  input  logic [NUM_CNT_BITS-1:0] rollover_value,
  input  logic [STEP_BITS-1:0]    step,
  output logic [NUM_CNT_BITS-1:0] count_out,
  output logic                    rollover_flag,
  output logic                    wrap_pulse,
  output logic                    done,
  output logic [WRAP_BITS-1:0]    wrap_count
);

  cnt_mode_t                 cur_mode;
  logic                      is_up;
  logic                      is_oneshot;
  logic                      terminal;
  logic [NUM_CNT_BITS-1:0]   next_count;

  assign cur_mode      = cnt_mode_t'(mode);
  assign is_up         = mode_is_up(cur_mode);
  assign is_oneshot    = mode_is_oneshot(cur_mode);
  assign terminal      = (count_out == rollover_value);
  assign rollover_flag = terminal;

  oscu_step_sat #(
    .NUM_CNT_BITS(NUM_CNT_BITS),
    .STEP_BITS   (STEP_BITS)
  ) u_step_sat (
    .count         (count_out),
    .rollover_value(rollover_value),
    .step          (step),
    .up            (is_up),
    .next_count    (next_count)
  );

  // Sequencer state: clear beats enable; a finished one-shot ignores enable.
  always_ff @(posedge clk2 or negedge NReset) begin
    if (!NReset) begin
      count_out  <= RESET_VAL;
      wrap_pulse <= 1'b0;
      done       <= 1'b0;
      wrap_count <= '0;
    end else begin
      wrap_pulse <= 1'b0;
      if (clear) begin
        count_out  <= start_value;
        done       <= 1'b0;
        wrap_count <= '0;
      end else if (count_enable && !(is_oneshot && done)) begin
        if (terminal) begin
          if (is_oneshot) begin
            done <= 1'b1;
          end else begin
            count_out  <= start_value;
            wrap_pulse <= 1'b1;
            if (wrap_count != '1) wrap_count <= wrap_count + 1'b1;
          end
        end else begin
          count_out <= next_count;
        end
      end
    end
  end

endmodule

// File: tb/tb_oscu_addr_sequencer.sv
// Directed self-checking bench for oscu_addr_sequencer (N=7, S=3, W=2).
module tb_oscu_addr_sequencer;

  logic       clk2;
  logic       NReset;
  logic       clear;
  logic       count_enable;
  logic [1:0] mode;
  logic [6:0] start_value;
  logic [6:0] rollover_value;
  logic [2:0] step;
  logic [6:0] count_out;
  logic       rollover_flag;
  logic       wrap_pulse;
  logic       done;
  logic [1:0] wrap_count;

  int checks = 0;
  int errors = 0;

  oscu_addr_sequencer #(
    .NUM_CNT_BITS(7),
    .STEP_BITS   (3),
    .WRAP_BITS   (2),
    .RESET_VAL   (7'd0)
  ) dut (
    .clk2          (clk2),
    .NReset        (NReset),
    .clear         (clear),
    .count_enable  (count_enable),
    .mode          (mode),
    .start_value   (start_value),
    .rollover_value(rollover_value),
    .step          (step),
    .count_out     (count_out),
    .rollover_flag (rollover_flag),
    .wrap_pulse    (wrap_pulse),
    .done          (done),
    .wrap_count    (wrap_count)
  );

  initial clk2 = 1'b0;
  always #5 clk2 = ~clk2;

  task automatic tick();
    @(posedge clk2);
    #1;
  endtask

  task automatic do_clear(input logic [1:0] m, input logic [6:0] s,
                          input logic [6:0] r, input logic [2:0] st);
    mode = m; start_value = s; rollover_value = r; step = st;
    clear = 1'b1; count_enable = 1'b0;
    tick();
    clear = 1'b0;
  endtask

  task automatic test_reset();
    NReset = 1'b0; clear = 1'b0; count_enable = 1'b0;
    mode = 2'b00; start_value = 7'd0; rollover_value = 7'd9; step = 3'd1;
    #12;
    checks++;
    if (count_out !== 7'd0 || wrap_pulse !== 1'b0 || done !== 1'b0 || wrap_count !== 2'd0) begin
      errors++;
      $display("FAIL reset_state: count=%0d wp=%b done=%b wc=%0d, required 0/0/0/0",
               count_out, wrap_pulse, done, wrap_count);
    end
    NReset = 1'b1;
    tick();
    checks++;
    if (count_out !== 7'd0) begin
      errors++;
      $display("FAIL reset_release_hold: count=%0d, required 0", count_out);
    end
  endtask

  task automatic test_wrap_up();
    logic [6:0] exp_cnt [5] = '{7'd6, 7'd7, 7'd8, 7'd9, 7'd5};
    logic       exp_wp  [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic       exp_rf  [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    do_clear(2'b00, 7'd5, 7'd9, 3'd1);
    checks++;
    if (count_out !== 7'd5) begin
      errors++;
      $display("FAIL wrap_up_clear: count=%0d, required 5", count_out);
    end
    count_enable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (count_out !== exp_cnt[i] || wrap_pulse !== exp_wp[i] || rollover_flag !== exp_rf[i]) begin
        errors++;
        $display("FAIL wrap_up_step%0d: count=%0d wp=%b rf=%b, required %0d/%b/%b",
                 i, count_out, wrap_pulse, rollover_flag, exp_cnt[i], exp_wp[i], exp_rf[i]);
      end
    end
    checks++;
    if (wrap_count !== 2'd1) begin
      errors++;
      $display("FAIL wrap_up_wcount: wc=%0d, required 1", wrap_count);
    end
    count_enable = 1'b0;
    tick();
    checks++;
    if (count_out !== 7'd5 || wrap_pulse !== 1'b0 || wrap_count !== 2'd1) begin
      errors++;
      $display("FAIL wrap_up_hold: count=%0d wp=%b wc=%0d, required 5/0/1",
               count_out, wrap_pulse, wrap_count);
    end
  endtask

  task automatic test_saturated_landing();
    logic [6:0] exp_cnt [5] = '{7'd3, 7'd6, 7'd9, 7'd10, 7'd0};
    do_clear(2'b00, 7'd0, 7'd10, 3'd3);
    count_enable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (count_out !== exp_cnt[i]) begin
        errors++;
        $display("FAIL sat_landing_step%0d: count=%0d, required %0d", i, count_out, exp_cnt[i]);
      end
    end
    count_enable = 1'b0;
  endtask

  task automatic test_oneshot_down();
    logic [6:0] exp_cnt  [5] = '{7'd13, 7'd6, 7'd4, 7'd4, 7'd4};
    logic       exp_done [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    do_clear(2'b11, 7'd20, 7'd4, 3'd7);
    checks++;
    if (count_out !== 7'd20) begin
      errors++;
      $display("FAIL oneshot_clear: count=%0d, required 20", count_out);
    end
    count_enable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (count_out !== exp_cnt[i] || done !== exp_done[i] || wrap_pulse !== 1'b0) begin
        errors++;
        $display("FAIL oneshot_step%0d: count=%0d done=%b wp=%b, required %0d/%b/0",
                 i, count_out, done, wrap_pulse, exp_cnt[i], exp_done[i]);
      end
    end
    count_enable = 1'b0;
    clear = 1'b1;
    tick();
    clear = 1'b0;
    checks++;
    if (count_out !== 7'd20 || done !== 1'b0) begin
      errors++;
      $display("FAIL oneshot_reclear: count=%0d done=%b, required 20/0", count_out, done);
    end
  endtask

  task automatic test_wrap_saturate();
    logic [6:0] exp_c;
    logic [1:0] exp_wc;
    do_clear(2'b00, 7'd0, 7'd1, 3'd1);
    count_enable = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      exp_c  = (k % 2 == 1) ? 7'd1 : 7'd0;
      exp_wc = (k / 2 >= 3) ? 2'd3 : 2'(k / 2);
      checks++;
      if (count_out !== exp_c || wrap_count !== exp_wc) begin
        errors++;
        $display("FAIL wrap_sat_cycle%0d: count=%0d wc=%0d, required %0d/%0d",
                 k, count_out, wrap_count, exp_c, exp_wc);
      end
    end
    count_enable = 1'b0;
  endtask

  task automatic test_edge_cases();
    // wrong side: count above rollover in up mode clamps on first step
    do_clear(2'b00, 7'd50, 7'd10, 3'd1);
    count_enable = 1'b1;
    tick();
    checks++;
    if (count_out !== 7'd10) begin
      errors++;
      $display("FAIL wrong_side_up: count=%0d, required 10", count_out);
    end
    // step zero holds a non-terminal count
    count_enable = 1'b0;
    do_clear(2'b10, 7'd40, 7'd10, 3'd0);
    count_enable = 1'b1;
    tick();
    checks++;
    if (count_out !== 7'd40 || wrap_pulse !== 1'b0) begin
      errors++;
      $display("FAIL step_zero_hold: count=%0d wp=%b, required 40/0", count_out, wrap_pulse);
    end
    // step zero at terminal still wraps
    count_enable = 1'b0;
    do_clear(2'b00, 7'd9, 7'd9, 3'd0);
    count_enable = 1'b1;
    tick();
    checks++;
    if (count_out !== 7'd9 || wrap_pulse !== 1'b1 || wrap_count !== 2'd1) begin
      errors++;
      $display("FAIL step_zero_terminal: count=%0d wp=%b wc=%0d, required 9/1/1",
               count_out, wrap_pulse, wrap_count);
    end
    count_enable = 1'b0;
    // near top of range: 125+3 would overflow 7 bits, must clamp to 127
    do_clear(2'b00, 7'd125, 7'd127, 3'd3);
    count_enable = 1'b1;
    tick();
    checks++;
    if (count_out !== 7'd127) begin
      errors++;
      $display("FAIL no_modulo_wrap: count=%0d, required 127", count_out);
    end
    count_enable = 1'b0;
  endtask

  task automatic test_async_reset_and_priority();
    do_clear(2'b00, 7'd30, 7'd100, 3'd7);
    count_enable = 1'b1;
    tick();
    count_enable = 1'b0;
    checks++;
    if (count_out !== 7'd37) begin
      errors++;
      $display("FAIL pre_reset_count: count=%0d, required 37", count_out);
    end
    #2 NReset = 1'b0;
    #1;
    checks++;
    if (count_out !== 7'd0 || wrap_pulse !== 1'b0 || done !== 1'b0 || wrap_count !== 2'd0) begin
      errors++;
      $display("FAIL async_reset: count=%0d wp=%b done=%b wc=%0d, required 0/0/0/0",
               count_out, wrap_pulse, done, wrap_count);
    end
    tick();
    NReset = 1'b1;
    start_value = 7'd50;
    clear = 1'b1;
    count_enable = 1'b1;
    tick();
    clear = 1'b0;
    count_enable = 1'b0;
    checks++;
    if (count_out !== 7'd50 || wrap_count !== 2'd0) begin
      errors++;
      $display("FAIL clear_priority: count=%0d wc=%0d, required 50/0", count_out, wrap_count);
    end
  endtask

  initial begin
    test_reset();
    test_wrap_up();
    test_saturated_landing();
    test_oneshot_down();
    test_wrap_saturate();
    test_edge_cases();
    test_async_reset_and_priority();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
